// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses instruction memory,
// captures the returned word into an instruction register and offers it
// to decode over a valid/ready handshake. Supports jumps, halt and a
// saturating count of completed handshakes.
module instruction_fetch #(
  parameter int unsigned               ADDR_WIDTH  = 8,
  parameter int unsigned               INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]     RESET_ADDR  = '0,
  parameter int unsigned               COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [INSTR_WIDTH-1:0] mem_instruction,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   jump_valid,
  input  logic [ADDR_WIDTH-1:0]  jump_address,
  input  logic                   halt_request,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instrPc;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_transfer;
  logic w_jump;
  logic w_load;

  // Handshake, jump acceptance (jumps are ignored in IDLE) and load decision;
  // a halt request in RUN suppresses the load of that same cycle.
  always_comb begin
    w_transfer = r_valid && instr_ready;
    w_jump     = jump_valid && (r_state != IDLE);
    w_load     = (r_state == RUN) && (!r_valid || w_transfer) &&
                 !jump_valid && !halt_request;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: jump always lands in RUN and beats a concurrent halt.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    w_nextState = RUN;
      RUN: begin
        if (w_jump)            w_nextState = RUN;
        else if (halt_request) w_nextState = HALTED;
      end
      HALTED: begin
        if (w_jump)            w_nextState = RUN;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Program counter: redirect on jump, advance (wrapping) on each load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_ADDR;
    end else if (w_jump) begin
      r_pc <= jump_address;
    end else if (w_load) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  // Instruction register: a jump flushes, a load refills, a bare transfer empties.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr   <= '0;
      r_instrPc <= '0;
      r_valid   <= 1'b0;
    end else if (w_jump) begin
      r_valid   <= 1'b0;
    end else if (w_load) begin
      r_instr   <= mem_instruction;
      r_instrPc <= r_pc;
      r_valid   <= 1'b1;
    end else if (w_transfer) begin
      r_valid   <= 1'b0;
    end
  end

  // Saturating count of completed handshakes, including one coinciding with a flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_transfer && (r_count != {COUNT_WIDTH{1'b1}})) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // Outputs come straight from registers; the memory address has no input path.
  always_comb begin
    mem_address = r_pc;
    instr_out   = r_instr;
    instr_pc    = r_instrPc;
    instr_valid = r_valid;
    halted      = (r_state == HALTED);
    fetch_count = r_count;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch. The memory model
// returns address*2+1, so every expected value below is hand-derived.
module tb_instruction_fetch;

  logic        clock;
  logic        resetN;
  logic [7:0]  memAddress;
  logic [31:0] memInstruction;
  logic [31:0] instrOut;
  logic [7:0]  instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        jumpValid;
  logic [7:0]  jumpAddress;
  logic        haltRequest;
  logic        halted;
  logic [15:0] fetchCount;

  int checks   = 0;
  int failures = 0;

  instruction_fetch dut (
    .clock           (clock),
    .reset_n         (resetN),
    .mem_address     (memAddress),
    .mem_instruction (memInstruction),
    .instr_out       (instrOut),
    .instr_pc        (instrPc),
    .instr_valid     (instrValid),
    .instr_ready     (instrReady),
    .jump_valid      (jumpValid),
    .jump_address    (jumpAddress),
    .halt_request    (haltRequest),
    .halted          (halted),
    .fetch_count     (fetchCount)
  );

  // Memory word at address n is n*2+1.
  assign memInstruction = {23'd0, memAddress, 1'b1};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the control inputs together.
  task automatic applyStimulus(input logic ready, input logic jmp, input logic [7:0] addr, input logic halt);
    instrReady  = ready;
    jumpValid   = jmp;
    jumpAddress = addr;
    haltRequest = halt;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check the full IR view in one call.
  task automatic checkIr(input string tag, input logic valid, input logic [31:0] instr, input logic [7:0] pc, input logic [15:0] count);
    checkOutput({tag, ".valid"}, 32'(instrValid), 32'(valid));
    checkOutput({tag, ".instr"}, instrOut, instr);
    checkOutput({tag, ".pc"},    32'(instrPc),    32'(pc));
    checkOutput({tag, ".count"}, 32'(fetchCount), 32'(count));
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #3;
    checkIr("reset", 1'b0, 32'd0, 8'd0, 16'd0);
    checkOutput("reset.halted", 32'(halted), 32'd0);
    checkOutput("reset.addr", 32'(memAddress), 32'd0);

    // Release between edges (after the edge at 15).
    @(posedge clock);
    @(posedge clock);
    #2 resetN = 1'b1;

    // Edge 1: IDLE -> RUN, nothing fetched yet.
    tick();
    checkOutput("e1.valid", 32'(instrValid), 32'd0);
    tick();
    checkIr("e2", 1'b1, 32'd1, 8'd0, 16'd0);
    tick();
    checkIr("e3", 1'b1, 32'd3, 8'd1, 16'd1);
    tick();
    checkIr("e4", 1'b1, 32'd5, 8'd2, 16'd2);

    // Stall three cycles: everything holds.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIr("stall", 1'b1, 32'd5, 8'd2, 16'd2);
      checkOutput("stall.addr", 32'(memAddress), 32'd3);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("unstall", 1'b1, 32'd7, 8'd3, 16'd3);
    checkOutput("unstall.addr", 32'(memAddress), 32'd4);

    // Jump to 0xFE with a valid IR not being accepted: flush, no count.
    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0);
    tick();
    checkOutput("jump.valid", 32'(instrValid), 32'd0);
    checkOutput("jump.addr", 32'(memAddress), 32'hFE);
    checkOutput("jump.count", 32'(fetchCount), 32'd3);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("jFE", 1'b1, 32'h1FD, 8'hFE, 16'd3);
    tick();
    checkIr("jFF", 1'b1, 32'h1FF, 8'hFF, 16'd4);
    tick();
    checkIr("wrap", 1'b1, 32'd1, 8'h00, 16'd5);
    checkOutput("wrap.addr", 32'(memAddress), 32'd1);

    // Halt with a valid IR and ready: IR transfers, no new load, pc frozen.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("halt.halted", 32'(halted), 32'd1);
    checkOutput("halt.valid", 32'(instrValid), 32'd0);
    checkOutput("halt.count", 32'(fetchCount), 32'd6);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("halted.halted", 32'(halted), 32'd1);
      checkOutput("halted.valid", 32'(instrValid), 32'd0);
      checkOutput("halted.addr", 32'(memAddress), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 8'h04, 1'b0);
    tick();
    checkOutput("resume.halted", 32'(halted), 32'd0);
    checkOutput("resume.addr", 32'(memAddress), 32'd4);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("resume", 1'b1, 32'd9, 8'd4, 16'd6);

    // Jump and halt together: jump wins; the concurrent transfer still counts.
    applyStimulus(1'b1, 1'b1, 8'h09, 1'b1);
    tick();
    checkOutput("jh.halted", 32'(halted), 32'd0);
    checkOutput("jh.valid", 32'(instrValid), 32'd0);
    checkOutput("jh.count", 32'(fetchCount), 32'd7);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("jh", 1'b1, 32'd19, 8'd9, 16'd7);
    checkOutput("jh.halted2", 32'(halted), 32'd0);

    // Reset asserted between edges: outputs clear at once.
    #2 resetN = 1'b0;
    #1;
    checkIr("midreset", 1'b0, 32'd0, 8'd0, 16'd0);
    checkOutput("midreset.halted", 32'(halted), 32'd0);
    checkOutput("midreset.addr", 32'(memAddress), 32'd0);
    tick();
    #2 resetN = 1'b1;

    // A jump in IDLE is ignored; the sequence restarts at address 0.
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b0);
    tick();
    checkOutput("r1.valid", 32'(instrValid), 32'd0);
    checkOutput("r1.addr", 32'(memAddress), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("r2", 1'b1, 32'd1, 8'd0, 16'd0);
    tick();
    checkIr("r3", 1'b1, 32'd3, 8'd1, 16'd1);
    tick();
    checkIr("r4", 1'b1, 32'd5, 8'd2, 16'd2);
    tick();
    checkIr("r5", 1'b1, 32'd7, 8'd3, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the CPU. Sits directly upstream of instruction_memory: it owns the program counter, drives the memory's 8-bit address, and captures the returned 32-bit instruction into an instruction register. It presents that register to the decode/execute stage over a valid/ready handshake. It also supports jumps (PC redirect with flush), halt, and a retired-fetch counter.

Parameters:
ADDR_WIDTH, 8, PC / memory address width (256 locations)
INSTR_WIDTH, 32, instruction width
RESET_ADDR, 0, PC value loaded on reset
COUNT_WIDTH, 16, width of fetch_count

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
mem_address  output  ADDR_WIDTH  address to instruction_memory; equals pc combinationally
mem_instruction  input  INSTR_WIDTH  combinational read data from instruction_memory
instr_out  output  INSTR_WIDTH  registered instruction to decode
instr_pc  output  ADDR_WIDTH  address instr_out was fetched from
instr_valid  output  1  instr_out holds an unconsumed instruction
instr_ready  input  1  decode accepts instr_out this cycle
jump_valid  input  1  one-cycle redirect request
jump_address  input  ADDR_WIDTH  redirect target
halt_request  input  1  one-cycle request to stop fetching
halted  output  1  high while in HALTED
fetch_count  output  COUNT_WIDTH  number of handshakes completed, saturating

Behaviour:
- Reset (async, reset_n=0): pc=RESET_ADDR; state=IDLE; instr_out=0; instr_pc=0; instr_valid=0; halted=0; fetch_count=0. Outputs take these values immediately, regardless of clock. This also applies to a reset mid-operation: any in-flight IR content is discarded.
- Transfer: occurs when instr_valid && instr_ready at a rising edge.
- Load condition: load = (state==RUN) && (!instr_valid || transfer) && !jump_valid.
- On load: instr_out<=mem_instruction; instr_pc<=pc; instr_valid<=1; pc<=pc+1.
- PC wrap: pc increments modulo 2^ADDR_WIDTH, so 255 wraps to 0 with no flag.
- Transfer without load: instr_valid<=0.
- State machine:
  - IDLE: one cycle after reset release -> RUN. No fetch.
  - RUN: fetch per the load rule. Back-to-back loads give one instruction per cycle while instr_ready=1. If instr_ready=0 with instr_valid=1, all of instr_out/instr_pc/instr_valid and pc hold (stall).
  - RUN + halt_request (no jump): -> HALTED, with no load that cycle. A valid IR is kept and may still transfer. pc holds.
  - HALTED: halted=1; no loads. Only jump_valid leaves HALTED (-> RUN).
- Jump (any state except IDLE; ignored in IDLE):
  - pc<=jump_address; instr_valid<=0 (flush). The state goes to RUN.
  - If a transfer occurs in the same cycle, it still counts: decode consumed the pre-flush instruction.
  - The first target instruction becomes valid one edge after the jump edge.
- Simultaneous jump_valid and halt_request: jump wins; halt_request is dropped.
- fetch_count: +1 on each transfer; saturates at 2^COUNT_WIDTH-1.
- mem_address is combinational from the pc register only; it has no path from any input.
- Latency: memory read to IR is 1 cycle. After reset release, instr_valid first rises after the 2nd rising edge.

Test Plan:
- Reset release, instr_ready=1, memory word at address n = n*2+1 -> edge2: instr_out=1, instr_pc=0; edge3: 3/1; edge4: 5/2; fetch_count=1,2,3 at edges 3,4,5.
- Stall: instr_ready=0 for 3 cycles while instr_out=5 (pc=3) -> instr_out, instr_pc=2 and pc=3 all held; on ready=1, next edge instr_out=7, instr_pc=3.
- Jump to 0xFE while instr_valid=1, ready=0 -> next edge instr_valid=0, mem_address=0xFE; following edges instr_pc=0xFE, then 0xFF, then 0x00 (wrap); fetch_count unchanged by the flush.
- halt_request in RUN with valid IR, ready=1 -> IR transfers, halted=1, instr_valid=0 thereafter for 5 cycles, pc frozen; then jump to 4 -> halted=0, instr_pc=4 one edge later.
- jump_valid and halt_request in the same cycle (target 9) -> halted stays 0, instr_pc=9 next load.
- Assert reset_n=0 mid-stream between edges -> all outputs zero immediately, mem_address=RESET_ADDR; after release the sequence from the first scenario repeats from address 0.
